l1a_smp_tagger: RTL and testbench

L1A_SMP_TAGGER -- requirements
Module: l1a_smp_tagger

---
 rtl/l1a_tag_pkg.sv | 37 +++
 rtl/l1a_win_tracker.sv | 32 +++
 rtl/l1a_smp_tagger.sv | 124 ++++++++++++
 tb/tb_l1a_smp_tagger.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1a_tag_pkg.sv
// rtl/l1a_tag_pkg.sv - field widths, tag bit offsets and defaults for the L1A sample tagger
package l1a_tag_pkg;

   localparam int DATA_W    = 12;
   localparam int SAMP_W    = 7;
   localparam int L1ACNT_W  = 24;
   localparam int L1AMCNT_W = 12;
   localparam int OCNT_W    = 4;
   localparam int CNT_W     = 5;
   localparam int TAG_W     = 44;
   localparam int NWIN_DEF  = 4;

   localparam int OFS_L1ACNT  = 0;
   localparam int OFS_L1AMCNT = 24;
   localparam int OFS_OCNT    = 36;
   localparam int OFS_MATCH   = 40;
   localparam int OFS_PHASE   = 41;
   localparam int OFS_OVRLAP  = 42;
   localparam int OFS_MULTI   = 43;

   localparam logic [CNT_W-1:0] OCNT_SAT = 5'd15;

   typedef struct packed {
      logic                 multi_ovlp;
      logic                 ovrlap;
      logic                 phase;
      logic                 match;
      logic [OCNT_W-1:0]    ocnt;
      logic [L1AMCNT_W-1:0] l1amcnt;
      logic [L1ACNT_W-1:0]  l1acnt;
   } tag_t;

   function automatic logic [OCNT_W-1:0] sat_ocnt(input logic [CNT_W-1:0] c);
      return (c > OCNT_SAT) ? OCNT_SAT[OCNT_W-1:0] : c[OCNT_W-1:0];
   endfunction

endpackage

// File: rtl/l1a_win_tracker.sv
// rtl/l1a_win_tracker.sv - one readout-window tracker: down-counter with busy flag
module l1a_win_tracker
   import l1a_tag_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_RESYNC,
   input  logic              i_load,
   input  logic [SAMP_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic              o_busy
);

   logic [SAMP_W-1:0] r_cnt;
   logic              r_busy;

   // A load always happens on the sample that opens the window, so that sample is already counted.
   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_cnt  <= i_load_val - 1'b1;
         r_busy <= (i_load_val > 7'd1);
      end else if (i_dec && r_busy) begin
         r_cnt  <= r_cnt - 1'b1;
         r_busy <= (r_cnt != 7'd1);
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/l1a_smp_tagger.sv
// rtl/l1a_smp_tagger.sv - tags ADC samples with L1A counters and window overlap info
// Optional macro L1A_PHASE_EN carries the latched L1A_PHASE into the tag phase bit.
module l1a_smp_tagger
   import l1a_tag_pkg::*;
#(
   parameter int NWIN = NWIN_DEF
) (
   input  logic              CLK,
   input  logic              RST_RESYNC,
   input  logic [SAMP_W-1:0] SAMP_MAX,
   input  logic [DATA_W-1:0] ADC_DATA,
   input  logic              ADC_VLD,
   input  logic              L1A,
   input  logic              L1A_MATCH,
   input  logic              L1A_PHASE,
   output logic [DATA_W-1:0] WDATA,
   output logic              WREN,
   output logic [TAG_W-1:0]  L1A_SMP_DATA,
   output logic              L1A_WRT_EN,
   output logic              L1A_DROP,
   output logic              WIN_OVF
);

   logic [L1ACNT_W-1:0]  r_l1acnt;
   logic [L1AMCNT_W-1:0] r_l1amcnt;
   logic                 r_pend, r_pend_match, r_pend_phase;

   logic [L1ACNT_W-1:0]  w_l1acnt_nxt;
   logic [L1AMCNT_W-1:0] w_l1amcnt_nxt;
   logic                 w_l1a_phase, w_consume, w_cur_match, w_cur_phase, w_want_open;
   logic [SAMP_W-1:0]    w_load_val;
   logic [NWIN-1:0]      w_busy, w_load;
   logic                 w_found;
   logic [CNT_W-1:0]     w_act, w_cnt;
   tag_t                 w_tag;

`ifdef L1A_PHASE_EN
   assign w_l1a_phase = L1A_PHASE;
`else
   logic w_unused_phase;
   assign w_unused_phase = L1A_PHASE;
   assign w_l1a_phase    = 1'b0;
`endif

   assign w_l1acnt_nxt  = L1A ? r_l1acnt + 1'b1 : r_l1acnt;
   assign w_l1amcnt_nxt = (L1A && L1A_MATCH) ? r_l1amcnt + 1'b1 : r_l1amcnt;
   assign w_consume     = ADC_VLD && (r_pend || L1A);
   assign w_cur_match   = r_pend ? r_pend_match : L1A_MATCH;
   assign w_cur_phase   = r_pend ? r_pend_phase : w_l1a_phase;
   assign w_want_open   = w_consume && w_cur_match;
   assign w_load_val    = (SAMP_MAX == '0) ? 7'd1 : SAMP_MAX;

   // Count windows covering this sample and hand a new window to the lowest free tracker.
   always_comb begin
      w_load  = '0;
      w_found = 1'b0;
      w_act   = '0;
      for (int i = 0; i < NWIN; i++) begin
         if (w_busy[i]) begin
            w_act = w_act + 5'd1;
         end else if (!w_found) begin
            w_found   = 1'b1;
            w_load[i] = w_want_open;
         end
      end
      w_cnt = w_act + {4'd0, (w_want_open && w_found)};
   end

   for (genvar g = 0; g < NWIN; g++) begin : g_trk
      l1a_win_tracker u_trk (
         .CLK        (CLK),
         .RST_RESYNC (RST_RESYNC),
         .i_load     (w_load[g]),
         .i_load_val (w_load_val),
         .i_dec      (ADC_VLD),
         .o_busy     (w_busy[g])
      );
   end

   always_comb begin
      w_tag            = '0;
      w_tag.multi_ovlp = (w_cnt >= 5'd3);
      w_tag.ovrlap     = (w_cnt >= 5'd2);
      w_tag.phase      = w_consume && w_cur_phase;
      w_tag.match      = w_consume && w_cur_match;
      w_tag.ocnt       = sat_ocnt(w_cnt);
      w_tag.l1amcnt    = w_l1amcnt_nxt;
      w_tag.l1acnt     = w_l1acnt_nxt;
   end

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         r_l1acnt     <= '0;
         r_l1amcnt    <= '0;
         r_pend       <= 1'b0;
         r_pend_match <= 1'b0;
         r_pend_phase <= 1'b0;
         WDATA        <= '0;
         WREN         <= 1'b0;
         L1A_SMP_DATA <= '0;
         L1A_WRT_EN   <= 1'b0;
         L1A_DROP     <= 1'b0;
         WIN_OVF      <= 1'b0;
      end else begin
         r_l1acnt   <= w_l1acnt_nxt;
         r_l1amcnt  <= w_l1amcnt_nxt;
         WREN       <= ADC_VLD;
         L1A_WRT_EN <= w_consume;
         L1A_DROP   <= L1A_DROP | (L1A && r_pend);
         WIN_OVF    <= WIN_OVF | (w_want_open && !w_found);
         // A strobe consumes any pending L1A; an L1A arriving while one is pending is dropped.
         if (ADC_VLD) begin
            r_pend       <= 1'b0;
            WDATA        <= ADC_DATA;
            L1A_SMP_DATA <= w_tag;
         end else if (L1A && !r_pend) begin
            r_pend       <= 1'b1;
            r_pend_match <= L1A_MATCH;
            r_pend_phase <= w_l1a_phase;
         end
      end
   end

endmodule

// File: tb/tb_l1a_smp_tagger.sv
// tb/tb_l1a_smp_tagger.sv - scoreboard bench for l1a_smp_tagger against a window-list reference model
module tb_l1a_smp_tagger;

   localparam int NWIN = 4;

   logic        CLK = 1'b0;
   logic        RST_RESYNC;
   logic [6:0]  SAMP_MAX;
   logic [11:0] ADC_DATA;
   logic        ADC_VLD, L1A, L1A_MATCH, L1A_PHASE;
   logic [11:0] WDATA;
   logic        WREN, L1A_WRT_EN, L1A_DROP, WIN_OVF;
   logic [43:0] L1A_SMP_DATA;

   l1a_smp_tagger #(.NWIN(NWIN)) dut (
      .CLK          (CLK),
      .RST_RESYNC   (RST_RESYNC),
      .SAMP_MAX     (SAMP_MAX),
      .ADC_DATA     (ADC_DATA),
      .ADC_VLD      (ADC_VLD),
      .L1A          (L1A),
      .L1A_MATCH    (L1A_MATCH),
      .L1A_PHASE    (L1A_PHASE),
      .WDATA        (WDATA),
      .WREN         (WREN),
      .L1A_SMP_DATA (L1A_SMP_DATA),
      .L1A_WRT_EN   (L1A_WRT_EN),
      .L1A_DROP     (L1A_DROP),
      .WIN_OVF      (WIN_OVF)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [11:0] d;
      logic        w;
      logic [43:0] t;
      logic        dr;
      logic        ov;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   logic [23:0] m_l1acnt;
   logic [11:0] m_l1amcnt;
   logic        m_pend, m_pm, m_pp, m_drop, m_ovf;
   int          m_samp;
   int          m_ends[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_l1acnt  = '0;
      m_l1amcnt = '0;
      m_pend    = 1'b0;
      m_pm      = 1'b0;
      m_pp      = 1'b0;
      m_drop    = 1'b0;
      m_ovf     = 1'b0;
      m_ends.delete();
   endtask

   task automatic step(input logic l1a, input logic match, input logic phase, input logic vld);
      logic [11:0] d;
      logic        consume, cm, cp;
      int          cnt, len;
      exp_t        e;
      d = 12'($urandom);
`ifndef L1A_PHASE_EN
      phase = 1'b0;
`endif
      if (l1a) begin
         m_l1acnt = m_l1acnt + 24'd1;
         if (match) m_l1amcnt = m_l1amcnt + 12'd1;
         if (m_pend) m_drop = 1'b1;
      end
      consume = vld && (m_pend || l1a);
      cm = m_pend ? m_pm : match;
      cp = m_pend ? m_pp : phase;
      if (vld) begin
         for (int i = m_ends.size() - 1; i >= 0; i--)
            if (m_ends[i] < m_samp) m_ends.delete(i);
         cnt = m_ends.size();
         if (consume && cm) begin
            if (cnt < NWIN) begin
               len = (SAMP_MAX == 0) ? 1 : int'(SAMP_MAX);
               m_ends.push_back(m_samp + len - 1);
               cnt++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         e.d  = d;
         e.w  = consume;
         e.t  = {(cnt >= 3), (cnt >= 2), consume && cp, consume && cm,
                 4'((cnt > 15) ? 15 : cnt), m_l1amcnt, m_l1acnt};
         e.dr = m_drop;
         e.ov = m_ovf;
         sbq.push_back(e);
         m_samp++;
         m_pend = 1'b0;
      end else if (l1a && !m_pend) begin
         m_pend = 1'b1;
         m_pm   = match;
         m_pp   = phase;
      end
      L1A = l1a; L1A_MATCH = match; L1A_PHASE = phase; ADC_VLD = vld; ADC_DATA = d;
      @(posedge CLK); #1;
   endtask

   task automatic check_zero_outputs();
      chk("rst_wdata", 64'(WDATA), 64'd0);
      chk("rst_wren", 64'(WREN), 64'd0);
      chk("rst_tag", 64'(L1A_SMP_DATA), 64'd0);
      chk("rst_wrt_en", 64'(L1A_WRT_EN), 64'd0);
      chk("rst_drop", 64'(L1A_DROP), 64'd0);
      chk("rst_ovf", 64'(WIN_OVF), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK); #1;
      L1A = 1'b0; ADC_VLD = 1'b0; L1A_MATCH = 1'b0; L1A_PHASE = 1'b0;
      RST_RESYNC = 1'b1;
      #1;
      check_zero_outputs();
      model_reset();
      @(negedge CLK);
      RST_RESYNC = 1'b0;
      @(posedge CLK); #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RST_RESYNC) begin
         if (L1A_WRT_EN) chk("wrt_en_needs_wren", 64'(WREN), 64'd1);
         if (WREN) begin
            if (sbq.size() == 0) begin
               chk("unexpected_wren_queue_size", 64'd0, 64'd1);
            end else begin
               e = sbq.pop_front();
               chk("wdata", 64'(WDATA), 64'(e.d));
               chk("wrt_en", 64'(L1A_WRT_EN), 64'(e.w));
               chk("tag", 64'(L1A_SMP_DATA), 64'(e.t));
               chk("l1a_drop", 64'(L1A_DROP), 64'(e.dr));
               chk("win_ovf", 64'(WIN_OVF), 64'(e.ov));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      RST_RESYNC = 1'b1; SAMP_MAX = 7'd8; ADC_DATA = '0;
      ADC_VLD = 1'b0; L1A = 1'b0; L1A_MATCH = 1'b0; L1A_PHASE = 1'b0;
      model_reset();
      m_samp = 0;
      #12;
      check_zero_outputs();
      @(negedge CLK); RST_RESYNC = 1'b0;
      @(posedge CLK); #1;

      // single matched L1A, strobe every 4 cycles
      step(1, 1, 1'($urandom), 0);
      repeat (12) begin
         step(0, 0, 0, 1);
         repeat (3) step(0, 0, 0, 0);
      end

      // two matched L1As three samples apart
      step(1, 1, 1'($urandom), 1);
      repeat (2) step(0, 0, 0, 1);
      step(1, 1, 1'($urandom), 1);
      repeat (12) step(0, 0, 0, 1);

      // two L1As between strobes
      step(1, 1, 1, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (10) step(0, 0, 0, 1);

      // tracker exhaustion
      SAMP_MAX = 7'd20;
      repeat (5) step(1, 1, 1'($urandom), 1);
      repeat (22) step(0, 0, 0, 1);

      // unmatched L1A
      step(1, 0, 1, 1);
      step(0, 0, 0, 1);

      // matched-counter wrap from a clean start
      do_reset();
      SAMP_MAX = 7'd1;
      repeat (4096) step(1, 1, 0, 1);
      step(0, 0, 0, 1);

      // random traffic, including SAMP_MAX changes and SAMP_MAX=0
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) SAMP_MAX = 7'($urandom_range(0, 24));
         step($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // reset in the middle of a window
      SAMP_MAX = 7'd30;
      step(1, 1, 0, 1);
      repeat (5) step(0, 0, 0, 1);
      do_reset();
      step(1, 1, 0, 1);
      repeat (3) step(0, 0, 0, 1);

      L1A = 1'b0; ADC_VLD = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
